// File: rtl/array_deser_if.sv
// array_deser_if: element input and vector output handshakes of the deserializer
interface array_deser_if #(
  parameter int LANES = 3,
  parameter int WIDTH = 1
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data [LANES-1:0];
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/array_deser.sv
// array_deser: assembles LANES serial elements into an unpacked array behind a valid/ready output
module array_deser #(
  parameter int LANES = 3,
  parameter int WIDTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  array_deser_if.slave bus
);
  localparam int IW = $clog2(LANES);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [WIDTH-1:0] asm_data [LANES-1:0];
  logic [WIDTH-1:0] out_nx [LANES-1:0];
  logic accept, drain, out_free, last, direct, from_hold, load, asm_we;
  assign bus.in_ready = rst_n && state == FILL;
  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    drain     = bus.out_valid && bus.out_ready;
    out_free  = !bus.out_valid || drain;
    last      = idx == IW'(LANES - 1);
    // the closing element can bypass the assembly buffer straight into the output register
    direct    = !flush && accept && last && out_free;
    from_hold = !flush && state == HOLD && out_free;
    load      = direct || from_hold;
    asm_we    = !flush && accept && !direct;
    state_nx  = flush ? FILL
              : (accept && last && !out_free) ? HOLD
              : from_hold ? FILL
              : state;
    idx_nx    = (flush || load) ? '0 : (accept && !last) ? idx + IW'(1) : idx;
    out_nx    = asm_data;
    out_nx[LANES-1] = direct ? bus.in_data : asm_data[LANES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      idx           <= '0;
      asm_data      <= '{default: '0};
      bus.out_data  <= '{default: '0};
      bus.out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (asm_we) asm_data[idx] <= bus.in_data;
      if (load) begin
        bus.out_data  <= out_nx;
        bus.out_valid <= 1'b1;
      end else if (drain) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_array_deser.sv
// tb_array_deser: directed table of the corner cases plus a randomized run against a queue-based model
module tb_array_deser;
  localparam int L = 3;
  localparam int W = 1;
  typedef struct {
    logic r, f, v;
    logic [W-1:0] d;
    logic o;
    logic [L*W+1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, flush;
  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  logic [W-1:0] part[$];
  logic [W-1:0] exp_out [L];
  logic exp_valid;
  array_deser_if #(.LANES(L), .WIDTH(W)) bus ();
  array_deser #(.LANES(L), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [L*W+1:0] observed();
    logic [L*W-1:0] p;
    for (int i = 0; i < L; i++) p[i*W +: W] = bus.out_data[i];
    return {bus.in_ready, bus.out_valid, p};
  endfunction
  function automatic logic [L*W+1:0] predicted();
    logic [L*W-1:0] p;
    for (int i = 0; i < L; i++) p[i*W +: W] = exp_out[i];
    return {rst_n && part.size() < L, exp_valid, p};
  endfunction
  // vectors complete whenever L elements are waiting and the output register is free
  function automatic void model_edge();
    logic dr, fr, xfer;
    if (!rst_n) begin
      part.delete();
      exp_valid = 1'b0;
      for (int i = 0; i < L; i++) exp_out[i] = '0;
      return;
    end
    dr = exp_valid && bus.out_ready;
    fr = !exp_valid || dr;
    xfer = 1'b0;
    if (flush) part.delete();
    else begin
      if (bus.in_valid && part.size() < L) part.push_back(bus.in_data);
      if (part.size() == L && fr) begin
        for (int i = 0; i < L; i++) exp_out[i] = part[i];
        part.delete();
        exp_valid = 1'b1;
        xfer = 1'b1;
      end
    end
    if (dr && !xfer) exp_valid = 1'b0;
  endfunction
  task automatic drive(input logic r, f, v, input logic [W-1:0] d, input logic o);
    rst_n = r;
    flush = f;
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = o;
    #1;
  endtask
  task automatic advance();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string name, input int n, input logic [L*W+1:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got ready/valid/data=%b required %b", name, n, act, exp);
    end
  endtask
  task automatic add(input logic r, f, v, d, o, ir, ov, input logic [L*W-1:0] od);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.d = W'(d); t.o = o;
    t.exp = {ir, ov, od};
    tbl.push_back(t);
  endtask
  initial begin
    // columns: rst_n flush in_valid in_data out_ready | in_ready out_valid {lane2,lane1,lane0}
    add(0,0,1,1,1, 0,0,3'b000); add(0,0,1,1,1, 0,0,3'b000);
    add(1,0,1,1,1, 1,0,3'b000); add(1,0,1,0,1, 1,0,3'b000); add(1,0,1,1,1, 1,0,3'b000);
    add(1,0,1,1,1, 1,1,3'b101); add(1,0,1,1,1, 1,0,3'b101); add(1,0,1,0,1, 1,0,3'b101);
    add(1,0,0,0,1, 1,1,3'b011);
    add(1,0,1,1,0, 1,0,3'b011); add(1,0,1,1,0, 1,0,3'b011); add(1,0,1,0,0, 1,0,3'b011);
    add(1,0,1,0,0, 1,1,3'b011); add(1,0,1,1,0, 1,1,3'b011); add(1,0,1,0,0, 1,1,3'b011);
    add(1,0,0,0,0, 0,1,3'b011); add(1,0,0,0,1, 0,1,3'b011); add(1,0,0,0,0, 1,1,3'b010);
    add(1,0,1,1,0, 1,1,3'b010); add(1,0,1,0,0, 1,1,3'b010); add(1,0,1,0,1, 1,1,3'b010);
    add(1,0,0,0,1, 1,1,3'b001); add(1,0,0,0,1, 1,0,3'b001);
    add(1,0,1,1,1, 1,0,3'b001); add(1,0,1,1,1, 1,0,3'b001); add(1,1,1,0,1, 1,0,3'b001);
    add(1,0,1,0,1, 1,0,3'b001); add(1,0,1,1,1, 1,0,3'b001); add(1,0,1,1,1, 1,0,3'b001);
    add(1,0,0,0,1, 1,1,3'b110);
    add(1,0,1,1,0, 1,0,3'b110); add(1,0,1,0,0, 1,0,3'b110); add(1,0,1,1,0, 1,0,3'b110);
    add(1,0,1,0,0, 1,1,3'b101); add(1,0,1,0,0, 1,1,3'b101); add(1,0,1,1,0, 1,1,3'b101);
    add(1,0,1,1,0, 0,1,3'b101); add(0,0,0,0,0, 0,1,3'b101);
    add(1,0,0,0,1, 1,0,3'b000); add(1,0,0,0,1, 1,0,3'b000);
    @(negedge clk);
    drive(0, 0, 0, '0, 0);
    advance();
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].o);
      check("directed", i, observed(), tbl[i].exp);
      advance();
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            W'($urandom), $urandom_range(0, 2) != 0);
      check("random", n, observed(), predicted());
      advance();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/array_deser.md
# array_deser

Serial-to-unpacked-array deserializer that sits directly upstream of the combinational array-processing stage and feeds its unpacked-array inputs. It accepts one WIDTH-bit element per handshake, assembles LANES elements into an unpacked array, and presents the completed array on a valid/ready output. A separate assembly buffer and output register let a new vector fill while the previous one waits to be consumed.

## Interface

- LANES, 3: elements per output vector; legal range 2..16.
- WIDTH, 1: bits per element; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous discard of partial or held assembly; output register untouched.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  element accepted when in_valid && in_ready.
- in_data  input  WIDTH  element payload.
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  downstream consumes when out_valid && out_ready.
- out_data  output  unpacked [LANES-1:0] of WIDTH  completed vector; element accepted first lands in out_data[0].

## Operation

- Storage: assembly array asm[LANES-1:0] of WIDTH, index idx (width $clog2(LANES)), state FILL/HOLD, output array out_data plus out_valid.
- accept = in_valid && in_ready; drain = out_valid && out_ready; out_free = !out_valid || drain.
- in_ready = rst_n && (state == FILL). Combinational; no dependence on in_valid.
- FILL, accept, idx < LANES-1: asm[idx] <= in_data; idx <= idx+1.
- FILL, accept, idx == LANES-1:
  - out_free: out_data <= {in_data at lane LANES-1, asm[LANES-2:0]}; out_valid <= 1; idx <= 0; stay FILL.
  - !out_free: asm[LANES-1] <= in_data; go HOLD.
- HOLD: in_ready = 0. When out_free: out_data <= asm; out_valid <= 1; idx <= 0; go FILL.
- drain with no transfer that cycle: out_valid <= 0; out_data keeps its last value.
- flush (rst_n high): idx <= 0, state <= FILL, any element presented that cycle is discarded even if in_ready was 1 (upstream sees it accepted). out_valid/out_data unaffected. flush overrides a same-cycle HOLD→output transfer; the held vector is lost.
- Lane order is strictly arrival order; idx wraps LANES-1→0 only on vector completion, never by overflow.
- No element is ever dropped or duplicated except by flush or reset.

## Timing

- Reset (rst_n low at a rising edge): idx = 0, state = FILL, out_valid = 0, out_data all lanes 0, asm all lanes 0. in_ready = 0 while rst_n low, 1 from the first cycle after release.
- Latency: last element of a vector accepted at edge t → out_valid = 1 after edge t, with out_data holding the full vector.
- Throughput: one element per cycle sustained when out_ready stays 1; back-to-back vectors have no bubble. The output completes one vector every LANES cycles.
- Stall: out_data and out_valid stable while out_valid && !out_ready.
- HOLD exit: out_free at edge t → transfer at t, in_ready = 1 in cycle t+1.
- Reset mid-vector or in HOLD: all partial and held data discarded; the pending output vector is dropped.

## Test plan

- Reset: hold rst_n low 2 cycles with in_valid=1 → in_ready=0, out_valid=0, out_data='{0,0,0}; after release, in_ready=1.
- Streaming (LANES=3, WIDTH=1, out_ready=1): send 1,0,1,1,1,0 on consecutive cycles → out_data[0..2]=1,0,1 valid one cycle after 3rd accept, then 1,1,0 three cycles later; in_ready never drops.
- Backpressure: out_ready=0, send 6 elements 1,1,0,0,1,0 → first vector presented and stable; in_ready drops after the 6th accept (HOLD). Raise out_ready for 1 cycle → second vector (0,1,0 in lanes 0..2) appears next cycle, in_ready=1.
- Simultaneous drain and completion: out_valid=1, out_ready=1 in the cycle the 3rd element is accepted → new vector replaces old the next cycle with no gap and no HOLD.
- Flush: accept 2 elements, pulse flush with in_valid=1 → element discarded, idx=0; the next 3 elements form a clean vector in lanes 0..2.
- Reset in HOLD: reach HOLD with out_valid=1, assert rst_n low 1 cycle → out_valid=0, in_ready=1 after release, no stale vector emitted.
